// File: rtl/wb_arbiter_if.sv
// Writeback request/grant bundle between the three writeback sources and the
// register-file write port, shared by the arbiter and whoever drives it.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;

  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_src;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  md_valid, md_rd, md_data,
    output alu_ready, ld_ready, md_ready,
    output rf_we, rf_waddr, rf_wdata, rf_src
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output md_valid, md_rd, md_data,
    input  alu_ready, ld_ready, md_ready,
    input  rf_we, rf_waddr, rf_wdata, rf_src
  );
endinterface

// File: rtl/wb_arbiter.sv
// Fixed-priority writeback arbiter (ALU > load > mul/div) with starvation
// counters that promote a stalled load or mul/div above the ALU.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave io_bus
);

  localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcAlu  = 2'd1,
    SrcLd   = 2'd2,
    SrcMd   = 2'd3
  } src_e;

  logic [3:0]  r_ld_wait, r_md_wait;
  logic [3:0]  w_ld_wait_next, w_md_wait_next;
  logic        w_ld_urgent, w_md_urgent;
  src_e        w_grant;
  logic [4:0]  w_rd;
  logic [31:0] w_data;

  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  src_e        r_rf_src;

  assign w_ld_urgent = (r_ld_wait == LimitCnt);
  assign w_md_urgent = (r_md_wait == LimitCnt);

  // Grant depends only on valids and counters; reset holds every ready low.
  always_comb begin
    w_grant = SrcNone;
    if (!reset) begin
      if (io_bus.ld_valid && w_ld_urgent) begin
        w_grant = SrcLd;
      end else if (io_bus.md_valid && w_md_urgent) begin
        w_grant = SrcMd;
      end else if (io_bus.alu_valid) begin
        w_grant = SrcAlu;
      end else if (io_bus.ld_valid) begin
        w_grant = SrcLd;
      end else if (io_bus.md_valid) begin
        w_grant = SrcMd;
      end
    end
  end

  assign io_bus.alu_ready = (w_grant == SrcAlu);
  assign io_bus.ld_ready  = (w_grant == SrcLd);
  assign io_bus.md_ready  = (w_grant == SrcMd);

  always_comb begin
    w_rd   = '0;
    w_data = '0;
    unique case (w_grant)
      SrcAlu: begin
        w_rd   = io_bus.alu_rd;
        w_data = io_bus.alu_data;
      end
      SrcLd: begin
        w_rd   = io_bus.ld_rd;
        w_data = io_bus.ld_data;
      end
      SrcMd: begin
        w_rd   = io_bus.md_rd;
        w_data = io_bus.md_data;
      end
      default: begin
        w_rd   = '0;
        w_data = '0;
      end
    endcase
  end

  always_comb begin
    w_ld_wait_next = r_ld_wait;
    w_md_wait_next = r_md_wait;
    if (!io_bus.ld_valid || io_bus.ld_ready) begin
      w_ld_wait_next = '0;
    end else if (r_ld_wait != LimitCnt) begin
      w_ld_wait_next = r_ld_wait + 4'd1;
    end
    if (!io_bus.md_valid || io_bus.md_ready) begin
      w_md_wait_next = '0;
    end else if (r_md_wait != LimitCnt) begin
      w_md_wait_next = r_md_wait + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_wait <= '0;
      r_md_wait <= '0;
    end else begin
      r_ld_wait <= w_ld_wait_next;
      r_md_wait <= w_md_wait_next;
    end
  end

  // A transfer to x0 still occupies the port but writes nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_rf_src   <= SrcNone;
    end else if (w_grant != SrcNone) begin
      r_rf_we    <= (w_rd != 5'd0);
      r_rf_waddr <= w_rd;
      r_rf_wdata <= (w_rd != 5'd0) ? w_data : 32'd0;
      r_rf_src   <= w_grant;
    end else begin
      r_rf_we    <= 1'b0;
      r_rf_src   <= SrcNone;
    end
  end

  assign io_bus.rf_we    = r_rf_we;
  assign io_bus.rf_waddr = r_rf_waddr;
  assign io_bus.rf_wdata = r_rf_wdata;
  assign io_bus.rf_src   = r_rf_src;

endmodule
